vector_lane_sequencer: RTL

- Multi-cycle vector execute engine that replaces the single-cycle, fixed 6-element vector ALU path.
- Processes a VECTOR_SIZE-element operation on LANES parallel ALU lanes over ceil(VECTOR_SIZE/LANES) beats.
- Sits in the Execute stage. Uses valid/ready handshakes toward Decode and Memory so the hazard unit can stall on busy.
- Also produces aggregated N/Z/V/C flags for the condition unit.

---
 rtl/vector_lane_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/vector_lane_sequencer.sv
// Multi-cycle vector execute engine: VECTOR_SIZE elements processed LANES per beat with N/Z/V/C aggregation.
// Optional per-element masking is enabled by defining VEC_SEQ_MASK_EN.
module vector_lane_sequencer #(
   parameter int DATA_WIDTH     = 8,
   parameter int VECTOR_SIZE    = 6,
   parameter int LANES          = 2,
   parameter int ALU_CTRL_WIDTH = 3
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              flush,
   input  logic                              inValid,
   output logic                              inReady,
   input  logic [ALU_CTRL_WIDTH-1:0]         aluControl,
   input  logic                              vectorScalar,
   input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] vectorA,
   input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] vectorB,
   input  logic [DATA_WIDTH-1:0]             scalarB,
`ifdef VEC_SEQ_MASK_EN
   input  logic [VECTOR_SIZE-1:0]            elementMask,
`endif
   output logic                              outValid,
   input  logic                              outReady,
   output logic [VECTOR_SIZE*DATA_WIDTH-1:0] result,
   output logic                              N,
   output logic                              Z,
   output logic                              V,
   output logic                              C,
   output logic                              busy
);

   localparam int VW    = VECTOR_SIZE * DATA_WIDTH;
   localparam int MSB   = DATA_WIDTH - 1;
   localparam int BEATS = (VECTOR_SIZE + LANES - 1) / LANES;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   localparam logic [ALU_CTRL_WIDTH-1:0] OP_ADD = ALU_CTRL_WIDTH'(0);
   localparam logic [ALU_CTRL_WIDTH-1:0] OP_SUB = ALU_CTRL_WIDTH'(1);
   localparam logic [ALU_CTRL_WIDTH-1:0] OP_AND = ALU_CTRL_WIDTH'(2);
   localparam logic [ALU_CTRL_WIDTH-1:0] OP_OR  = ALU_CTRL_WIDTH'(3);
   localparam logic [ALU_CTRL_WIDTH-1:0] OP_XOR = ALU_CTRL_WIDTH'(4);
   localparam logic [ALU_CTRL_WIDTH-1:0] OP_MUL = ALU_CTRL_WIDTH'(5);
   localparam logic [ALU_CTRL_WIDTH-1:0] OP_B   = ALU_CTRL_WIDTH'(6);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   typedef struct packed {
      logic                  carry;
      logic                  ovf;
      logic [DATA_WIDTH-1:0] value;
   } lane_t;

   state_t                    state, state_next;
   logic [BW-1:0]             beat;
   logic [ALU_CTRL_WIDTH-1:0] op_ctrl;
   logic [VW-1:0]             op_a, op_b;
   logic [VECTOR_SIZE-1:0]    op_mask;
   logic                      n_acc, z_acc, v_acc, c_acc;
   logic                      n_next, z_next, v_next, c_next;
   logic [VW-1:0]             result_next;

   function automatic lane_t alu(input logic [ALU_CTRL_WIDTH-1:0] op,
                                 input logic [DATA_WIDTH-1:0] a,
                                 input logic [DATA_WIDTH-1:0] b);
      lane_t           o;
      logic [DATA_WIDTH:0] wide;
      o    = '0;
      wide = '0;
      case (op)
         OP_ADD: begin
            wide    = {1'b0, a} + {1'b0, b};
            o.value = wide[DATA_WIDTH-1:0];
            o.carry = wide[DATA_WIDTH];
            o.ovf   = (a[MSB] == b[MSB]) && (o.value[MSB] != a[MSB]);
         end
         OP_SUB: begin
            // The extra bit of a zero-extended difference is the borrow.
            wide    = {1'b0, a} - {1'b0, b};
            o.value = wide[DATA_WIDTH-1:0];
            o.carry = wide[DATA_WIDTH];
            o.ovf   = (a[MSB] != b[MSB]) && (o.value[MSB] != a[MSB]);
         end
         OP_AND:  o.value = a & b;
         OP_OR:   o.value = a | b;
         OP_XOR:  o.value = a ^ b;
         OP_MUL:  o.value = a * b;
         OP_B:    o.value = b;
         default: o.value = a;
      endcase
      return o;
   endfunction

`ifndef VEC_SEQ_MASK_EN
   assign op_mask = '1;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: every output and next-state value is defaulted first so no path through the case infers a latch.
   always_comb begin
      state_next = state;
      inReady    = 1'b0;
      outValid   = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            inReady = 1'b1;
            if (inValid) state_next = RUN;
         end
         RUN:  if (beat == LAST_BEAT) state_next = DONE;
         DONE: begin
            outValid = 1'b1;
            if (outReady) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
   end

   // Looping over real elements only means lanes past VECTOR_SIZE in the last beat never exist.
   always_comb begin
      lane_t elem;
      elem        = '0;
      result_next = result;
      n_next      = n_acc;
      z_next      = z_acc;
      v_next      = v_acc;
      c_next      = c_acc;
      for (int i = 0; i < VECTOR_SIZE; i++) begin
         if (beat == BW'(i / LANES)) begin
            elem = alu(op_ctrl, op_a[i*DATA_WIDTH +: DATA_WIDTH], op_b[i*DATA_WIDTH +: DATA_WIDTH]);
            if (op_mask[i]) begin
               result_next[i*DATA_WIDTH +: DATA_WIDTH] = elem.value;
               n_next = n_next | elem.value[MSB];
               z_next = z_next & (elem.value == '0);
               v_next = v_next | elem.ovf;
               c_next = c_next | elem.carry;
            end else begin
               result_next[i*DATA_WIDTH +: DATA_WIDTH] = op_a[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   // NOTE: operand registers are reset too, so nothing from an aborted operation survives a reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         beat    <= '0;
         op_ctrl <= '0;
         op_a    <= '0;
         op_b    <= '0;
`ifdef VEC_SEQ_MASK_EN
         op_mask <= '0;
`endif
         result  <= '0;
         n_acc   <= 1'b0;
         z_acc   <= 1'b1;
         v_acc   <= 1'b0;
         c_acc   <= 1'b0;
         N       <= 1'b0;
         Z       <= 1'b0;
         V       <= 1'b0;
         C       <= 1'b0;
      end else if (!flush) begin
         if (state == IDLE && inValid) begin
            beat    <= '0;
            op_ctrl <= aluControl;
            op_a    <= vectorA;
            op_b    <= vectorScalar ? {VECTOR_SIZE{scalarB}} : vectorB;
`ifdef VEC_SEQ_MASK_EN
            op_mask <= elementMask;
`endif
            result  <= '0;
            n_acc   <= 1'b0;
            z_acc   <= 1'b1;
            v_acc   <= 1'b0;
            c_acc   <= 1'b0;
         end else if (state == RUN) begin
            result <= result_next;
            n_acc  <= n_next;
            z_acc  <= z_next;
            v_acc  <= v_next;
            c_acc  <= c_next;
            if (beat == LAST_BEAT) begin
               beat <= '0;
               N    <= n_next;
               Z    <= z_next;
               V    <= v_next;
               C    <= c_next;
            end else begin
               beat <= beat + BW'(1);
            end
         end
      end
   end

endmodule
